// File: rtl/udp_tx_sched_pkg.sv
// udp_tx_sched_pkg: shared types and constants for the UDP TX word scheduler.
//   sched_state_t : scheduler FSM state encoding
//   PAYLOAD_W     : payload word width in bits
package udp_tx_sched_pkg;

  localparam int unsigned PAYLOAD_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitReq,
    StWaitDone,
    StGap
  } sched_state_t;

endpackage

// File: rtl/minififo.sv
// minififo: small word FIFO storage with wrapping read/write pointers.
// Occupancy and full/empty tracking belong to the instantiating block, which
// must never write when full or read when empty.
//   clk, reset : clock and asynchronous active-high reset (clears pointers)
//   wr, wdata  : write strobe and data
//   rd         : advance the read pointer (pop)
//   rdata      : head word, combinational from the read pointer
module minififo #(
  parameter int unsigned D = 16,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata
);

  localparam int unsigned AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;

  // Pointers are exactly log2(D) bits so they wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];

endmodule

// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: buffers 32-bit payload words and launches one UDP frame
// per word into udp_tx_machine, waits for the frame to complete, then holds
// off for a minimum inter-frame gap.
// Optional build macro: UDP_TX_SCHED_STATS_EN enables the saturating
// sent_cnt / drop_cnt statistics counters (tied to 0 otherwise).
//   clk, reset          : clock, asynchronous active-high reset
//   in_vld, in_data     : word write strobe and payload
//   in_full, level      : buffer full flag and occupancy (0..DEPTH)
//   tx_udp_go/dvld/data : registered one-cycle launch pulse and head word
//   udp_tx_req          : frame pending/in flight, from udp_tx_machine
//   tx_busy             : MAC transmitter busy, from eth
//   sent_cnt, drop_cnt  : frames launched / words dropped (stats build)
module udp_tx_scheduler
  import udp_tx_sched_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned GAP_CYCLES  = 5000,
  parameter int unsigned REQ_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vld,
  input  logic [PAYLOAD_W-1:0]   in_data,
  output logic                   in_full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tx_udp_go,
  output logic                   tx_udp_dvld,
  output logic [PAYLOAD_W-1:0]   tx_udp_data,
  input  logic                   udp_tx_req,
  input  logic                   tx_busy,
  output logic [15:0]            sent_cnt,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned LvlW = $clog2(DEPTH) + 1;
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned ToW  = $clog2(REQ_TIMEOUT + 1);
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ToW-1:0]  ToLast  = ToW'(REQ_TIMEOUT - 1);

  sched_state_t         state_q, state_d;
  logic [LvlW-1:0]      level_q;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [ToW-1:0]       to_q, to_d;
  logic                 go_q;
  logic [PAYLOAD_W-1:0] data_q;
  logic [PAYLOAD_W-1:0] head;
  logic                 push, pop, end_frame;

  assign in_full = (level_q == LvlW'(DEPTH));
  // Full is judged on the registered level, so a pop in the same cycle
  // does not rescue a write to a full buffer.
  assign push    = in_vld & ~in_full;
  assign pop     = (state_q == StLaunch);

  minififo #(
    .D (DEPTH),
    .W (PAYLOAD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .wdata (in_data),
    .rd    (pop),
    .rdata (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else if (push && !pop) begin
      level_q <= level_q + 1'b1;
    end else if (pop && !push) begin
      level_q <= level_q - 1'b1;
    end
  end

  // Frame is over: request timed out (a request arriving on the expiry cycle
  // still wins), or the machine and MAC have both gone quiet.
  assign end_frame = ((state_q == StWaitReq) && !udp_tx_req && (to_q == ToLast)) ||
                     ((state_q == StWaitDone) && !udp_tx_req && !tx_busy);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle:     if (level_q != '0) state_d = StLaunch;
      StLaunch: begin
        state_d = StWaitReq;
        to_d    = '0;
      end
      StWaitReq: begin
        if (udp_tx_req) state_d = StWaitDone;
        else if (to_q != ToLast) to_d = to_q + 1'b1;
      end
      StWaitDone: ;
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else gap_d = gap_q - 1'b1;
      end
      default:    state_d = StIdle;
    endcase
    if (end_frame) begin
      if (GAP_CYCLES == 0) begin
        state_d = StIdle;
      end else begin
        state_d = StGap;
        gap_d   = GapLoad;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gap_q   <= '0;
      to_q    <= '0;
      go_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      // Registered launch outputs line up with the LAUNCH state cycle.
      go_q    <= (state_d == StLaunch);
      data_q  <= (state_d == StLaunch) ? head : '0;
    end
  end

  assign tx_udp_go   = go_q;
  assign tx_udp_dvld = go_q;
  assign tx_udp_data = data_q;
  assign level       = level_q;

`ifdef UDP_TX_SCHED_STATS_EN
  logic [15:0] sent_q, drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_q <= '0;
      drop_q <= '0;
    end else begin
      if (pop && (sent_q != 16'hFFFF)) sent_q <= sent_q + 16'd1;
      if (in_vld && in_full && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign sent_cnt = sent_q;
  assign drop_cnt = drop_q;
`else
  assign sent_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule
